// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: word width, fixed instruction encodings and the
// fetch-stage state encoding.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP   = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_ECALL = 32'h0000_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/pc/instr with flush (wins), load and hold.
// Resets asynchronously to an invalid NOP at pc 0.
module if_id_reg
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;

    // A flush only drops the valid bit; pc/instr keep their stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= INSTR_NOP;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, redirect target adder, BOOT/RUN/HALT
// FSM, delivered-instruction counter, and the IF/ID register feeding decode.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        id_stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] redirect_imm,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fetch_count;
    logic            r_misalign;

    logic [XLEN-1:0] w_target;
    logic            w_load;
    logic            w_flush;

    assign w_target = redirect_pc + redirect_imm;

    // Redirect beats stall beats memory response; a redirect always flushes.
    always_comb begin
        w_load  = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            BOOT: w_flush = redirect_en;
            RUN: begin
                if (redirect_en) begin
                    w_flush = 1'b1;
                end else if (!id_stall) begin
                    w_load  = imem_ready;
                    w_flush = !imem_ready;
                end
            end
            HALT:    w_flush = redirect_en || !id_stall;
            default: w_flush = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
            r_misalign    <= 1'b0;
        end else begin
            if (redirect_en) begin
                r_pc <= align_word(w_target);
                if (w_target[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end else if (w_load) begin
                r_pc          <= r_pc + 32'd4;
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (w_load && imem_rdata == INSTR_ECALL) begin
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    if (redirect_en) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_instr (imem_rdata),
        .o_valid (if_id_valid),
        .o_pc    (if_id_pc),
        .o_instr (if_id_instr)
    );

    assign imem_req     = (r_state == RUN);
    assign imem_addr    = r_pc;
    assign halted       = (r_state == HALT);
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        id_stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_imm;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .id_stall     (id_stall),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .redirect_imm (redirect_imm),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .halted       (halted),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    // Instruction memory image: two fixed words at 0/4, an optional ECALL
    // site, and an address-derived non-ECALL word everywhere else.
    logic [31:0] ecall_addr = 32'h0000_0001;
    bit          rand_ecall = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[27:2], 6'b010011};
        if (a == 32'h0) w = 32'h00C0_0933;
        if (a == 32'h4) w = 32'h0040_0513;
        if (rand_ecall && a[6:2] == 5'h15) w = 32'h0000_0073;
        if (a == ecall_addr) w = 32'h0000_0073;
        return w;
    endfunction

    always_comb begin
        imem_rdata = {imem_addr[27:2], 6'b010011};
        if (imem_addr == 32'h0) imem_rdata = 32'h00C0_0933;
        if (imem_addr == 32'h4) imem_rdata = 32'h0040_0513;
        if (rand_ecall && imem_addr[6:2] == 5'h15) imem_rdata = 32'h0000_0073;
        if (imem_addr == ecall_addr) imem_rdata = 32'h0000_0073;
    end

    // Behavioural model: 0 = boot, 1 = fetching, 2 = halted.
    int          m_state;
    logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
    logic        m_v, m_mis;

    task automatic model_reset();
        m_state = 0; m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0;
        m_instr = 32'h13; m_cnt = 32'h0; m_mis = 1'b0;
    endtask

    task automatic model_step(input bit rd, input logic [31:0] rpc, input logic [31:0] rimm,
                              input bit st, input bit rdy, input logic [31:0] word);
        logic [31:0] tgt;
        tgt = rpc + rimm;
        if (rd) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            if (tgt % 4 != 0) m_mis = 1'b1;
            if (m_state != 0) m_v = 1'b0;
            m_state = 1;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (!st) begin
                if (rdy) begin
                    m_v = 1'b1; m_ipc = m_pc; m_instr = word;
                    m_pc = m_pc + 4; m_cnt = m_cnt + 1;
                    if (word == 32'h73) m_state = 2;
                end else begin
                    m_v = 1'b0;
                end
            end
        end else if (!st) begin
            m_v = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle #1.
    task automatic cycle(input bit rd, input logic [31:0] rpc, input logic [31:0] rimm,
                         input bit st, input bit rdy);
        redirect_en = rd; redirect_pc = rpc; redirect_imm = rimm;
        id_stall = st; imem_ready = rdy;
        @(posedge clk);
        model_step(rd, rpc, rimm, st, rdy, mem_word(m_pc));
        #1;
        $display("cyc t=%0t rd=%b st=%b rdy=%b | req=%b addr=%h v=%b pc=%h instr=%h halt=%b mis=%b cnt=%0d",
                 $time, rd, st, rdy, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr,
                 halted, misalign_err, fetch_count);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_en = 0; redirect_pc = 0; redirect_imm = 0;
        id_stall = 0; imem_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, misalign_err, fetch_count}
            !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h13, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got req=%b addr=%h v=%b pc=%h instr=%h halt=%b mis=%b cnt=%0d want 0/0/0/0/00000013/0/0/0",
                     imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, misalign_err, fetch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fetch();
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL fetch_edge1: got v=%b req=%b addr=%h want v=0 req=1 addr=0", if_id_valid, imem_req, imem_addr);
        end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h00C0_0933) begin
            n_bad++;
            $display("FAIL fetch_edge2: got v=%b pc=%h instr=%h want v=1 pc=0 instr=00c00933", if_id_valid, if_id_pc, if_id_instr);
        end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || if_id_instr !== 32'h0040_0513 || fetch_count !== 32'd2) begin
            n_bad++;
            $display("FAIL fetch_edge3: got v=%b pc=%h instr=%h cnt=%0d want v=1 pc=4 instr=00400513 cnt=2",
                     if_id_valid, if_id_pc, if_id_instr, fetch_count);
        end
    endtask

    task automatic test_mem_stall();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0);
            n_cmp++;
            if (if_id_valid !== 1'b0 || imem_addr !== 32'h8) begin
                n_bad++;
                $display("FAIL mem_stall_%0d: got v=%b addr=%h want v=0 addr=8", i, if_id_valid, imem_addr);
            end
        end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== 32'h0000_0093 || fetch_count !== 32'd3) begin
            n_bad++;
            $display("FAIL mem_stall_resume: got v=%b pc=%h instr=%h cnt=%0d want v=1 pc=8 instr=00000093 cnt=3",
                     if_id_valid, if_id_pc, if_id_instr, fetch_count);
        end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_stall_redirect();
        cycle(1, 32'h20, 32'hFFFF_FFF0, 1, 1);
        n_cmp++;
        if (imem_addr !== 32'h10 || if_id_valid !== 1'b0 || fetch_count !== 32'd4) begin
            n_bad++;
            $display("FAIL stall_redirect: got addr=%h v=%b cnt=%0d want addr=10 v=0 cnt=4", imem_addr, if_id_valid, fetch_count);
        end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10 || if_id_instr !== 32'h0000_0113) begin
            n_bad++;
            $display("FAIL redirect_target: got v=%b pc=%h instr=%h want v=1 pc=10 instr=00000113", if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_wrap_misalign();
        cycle(1, 32'hFFFF_FFFC, 32'h6, 0, 1);
        n_cmp++;
        if (imem_addr !== 32'h0 || misalign_err !== 1'b1 || if_id_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_misalign: got addr=%h mis=%b v=%b want addr=0 mis=1 v=0", imem_addr, misalign_err, if_id_valid);
        end
        ecall_addr = 32'h40;
        cycle(1, 32'h30, 32'h10, 0, 1);
        n_cmp++;
        if (imem_addr !== 32'h40 || misalign_err !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign_sticky: got addr=%h mis=%b want addr=40 mis=1", imem_addr, misalign_err);
        end
    endtask

    task automatic test_halt();
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_instr !== 32'h73 ||
            halted !== 1'b1 || imem_req !== 1'b0 || fetch_count !== 32'd6) begin
            n_bad++;
            $display("FAIL halt_enter: got v=%b pc=%h instr=%h halt=%b req=%b cnt=%0d want 1/40/00000073/1/0/6",
                     if_id_valid, if_id_pc, if_id_instr, halted, imem_req, fetch_count);
        end
        cycle(0, 0, 0, 1, 1);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || halted !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_stall_hold: got v=%b pc=%h halt=%b want v=1 pc=40 halt=1", if_id_valid, if_id_pc, halted);
        end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_id_valid !== 1'b0 || halted !== 1'b1 || fetch_count !== 32'd6) begin
            n_bad++;
            $display("FAIL halt_drain: got v=%b halt=%b cnt=%0d want v=0 halt=1 cnt=6", if_id_valid, halted, fetch_count);
        end
        cycle(1, 32'h100, 32'h0, 0, 1);
        ecall_addr = 32'h1;
        n_cmp++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL halt_exit: got halt=%b req=%b addr=%h want halt=0 req=1 addr=100", halted, imem_req, imem_addr);
        end
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== 32'h0000_1013 || fetch_count !== 32'd7) begin
            n_bad++;
            $display("FAIL halt_resume: got v=%b pc=%h instr=%h cnt=%0d want v=1 pc=100 instr=00001013 cnt=7",
                     if_id_valid, if_id_pc, if_id_instr, fetch_count);
        end
    endtask

    task automatic test_midrun_reset();
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, misalign_err, fetch_count}
            !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h13, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL async_reset: got req=%b addr=%h v=%b pc=%h instr=%h halt=%b mis=%b cnt=%0d want 0/0/0/0/00000013/0/0/0",
                     imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, misalign_err, fetch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h00C0_0933) begin
            n_bad++;
            $display("FAIL reset_latency: got v=%b pc=%h instr=%h want v=1 pc=0 instr=00c00933", if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_random();
        bit          rd, st, rdy;
        logic [31:0] rpc, rimm;
        rand_ecall = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rd   = ($urandom % 100) < 8;
            st   = ($urandom % 100) < 20;
            rdy  = ($urandom % 100) < 75;
            rpc  = 32'($urandom_range(0, 255)) << 2;
            rimm = (32'($urandom_range(0, 64)) << 2) - 32'd128;
            if ($urandom % 12 == 0) rimm = rimm + 32'($urandom_range(1, 3));
            cycle(rd, rpc, rimm, st, rdy);
            n_cmp++;
            if ({imem_req, imem_addr, if_id_valid, halted, misalign_err, fetch_count}
                !== {m_state == 1, m_pc, m_v, m_state == 2, m_mis, m_cnt}) begin
                n_bad++;
                $display("FAIL random_%0d status: got req=%b addr=%h v=%b halt=%b mis=%b cnt=%0d want req=%b addr=%h v=%b halt=%b mis=%b cnt=%0d",
                         i, imem_req, imem_addr, if_id_valid, halted, misalign_err, fetch_count,
                         m_state == 1, m_pc, m_v, m_state == 2, m_mis, m_cnt);
            end
            if (m_v) begin
                n_cmp++;
                if (if_id_pc !== m_ipc || if_id_instr !== m_instr) begin
                    n_bad++;
                    $display("FAIL random_%0d ifid: got pc=%h instr=%h want pc=%h instr=%h",
                             i, if_id_pc, if_id_instr, m_ipc, m_instr);
                end
            end
        end
        rand_ecall = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fetch();
        test_mem_stall();
        test_stall_redirect();
        test_wrap_misalign();
        test_halt();
        test_midrun_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
